// File: rtl/md_unit_ctrl_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide unit.
package md_unit_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_ctrl_arith.sv
// Combinational 64-bit product or {remainder, quotient} for latched operands.
module md_arith
    import md_unit_ctrl_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] res_o,
    output logic        dz_o
);

    logic        sgn_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] ub_safe;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;
    logic [63:0] sa;
    logic [63:0] sb;

    always_comb begin
        sgn_div = (op_i == MD_DIV);
        a_neg   = sgn_div & a_i[31];
        b_neg   = sgn_div & b_i[31];
        ua      = a_neg ? -a_i : a_i;
        ub      = b_neg ? -b_i : b_i;
        dz_o    = (b_i == 32'd0) & ((op_i == MD_DIV) | (op_i == MD_DIVU));
        // Keep the divider X-free on zero; the result is discarded anyway.
        ub_safe = (ub == 32'd0) ? 32'd1 : ub;
        uq      = ua / ub_safe;
        ur      = ua % ub_safe;
        q       = (a_neg ^ b_neg) ? -uq : uq;
        r       = a_neg ? -ur : ur;
        sa      = {{32{a_i[31]}}, a_i};
        sb      = {{32{b_i[31]}}, b_i};
        res_o   = 64'd0;
        unique case (op_i)
            MD_MULT:  res_o = sa * sb;
            MD_MULTU: res_o = {32'd0, a_i} * {32'd0, b_i};
            MD_DIV,
            MD_DIVU:  res_o = {r, q};
            default:  res_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// HI/LO owner: sequences fixed-latency MULT/DIV and requests D-stage stalls.
module md_unit_ctrl
    import md_unit_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES - 1);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] res;
    logic        dz;

    md_arith u_arith (
        .op_i  (op_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .res_o (res),
        .dz_o  (dz)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && is_arith(md_op)) begin
                    op_d    = md_op;
                    a_d     = rs_data;
                    b_d     = rt_data;
                    cnt_d   = (md_op == MD_MULT || md_op == MD_MULTU)
                              ? MULT_LD : DIV_LD;
                    state_d = ST_RUN;
                end else if (start && md_op == MD_MTHI) begin
                    hi_d = rs_data;
                end else if (start && md_op == MD_MTLO) begin
                    lo_d = rs_data;
                end
            end
            ST_RUN: begin
                if (cnt_q == 4'd0) begin
                    if (!dz) begin
                        hi_d = res[63:32];
                        lo_d = res[31:0];
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign stall_md = (busy | (start & is_arith(md_op))) & d_is_md;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: directed scenarios plus randomized ops vs a model.
module tb_md_unit_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        d_is_md = 1'b0;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    always #5 clk = ~clk;

    md_unit_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .d_is_md  (d_is_md),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    function automatic logic [63:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] h,
                                          input logic [31:0] l);
        longint sq;
        longint sr;
        logic [63:0] r;
        r = {h, l};
        case (op)
            3'd1: r = 64'(longint'($signed(a)) * longint'($signed(b)));
            3'd2: r = {32'd0, a} * {32'd0, b};
            3'd3: if (b != 32'd0) begin
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) % longint'($signed(b));
                r = {sr[31:0], sq[31:0]};
            end
            3'd4: if (b != 32'd0) r = {a % b, a / b};
            3'd5: r = {a, l};
            3'd6: r = {h, a};
            default: ;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 5;
        if (op == 3'd3 || op == 3'd4) return 10;
        return 0;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    // Counts busy cycles (bounded), scrambling operands meanwhile.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            rs_data = $urandom;
            rt_data = $urandom;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        d_is_md = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_md !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b stall=%b hi=%h lo=%h want 0 0 0 0",
                     busy, stall_md, hi, lo);
        end
        start = 1'b1;
        md_op = 3'd1;
        rs_data = 32'd3;
        rt_data = 32'd4;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        reset = 1'b0;
        d_is_md = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_start: busy=%b want 0", busy);
        end
        hi_m = 32'd0;
        lo_m = 32'd0;
    endtask

    task automatic test_mult();
        int n;
        @(negedge clk);
        start = 1'b1;
        md_op = 3'd1;
        rs_data = 32'hFFFFFFFE;
        rt_data = 32'd3;
        d_is_md = 1'b1;
        #1;
        checks++;
        if (stall_md !== 1'b1) begin
            errors++;
            $display("FAIL stall_on_start: stall=%b want 1", stall_md);
        end
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        d_is_md = 1'b0;
        wait_idle(n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL mult_busy_len: got %0d want 5", n);
        end
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL mult_result: hi=%h lo=%h want ffffffff fffffffa", hi, lo);
        end
        hi_m = hi_m; // model state now tracked literally below
        hi_m = 32'hFFFFFFFF;
        lo_m = 32'hFFFFFFFA;
    endtask

    task automatic test_divu_stall();
        int n;
        issue(3'd4, 32'd100, 32'd7);
        n = 0;
        while (busy && n < 40) begin
            d_is_md = (n % 3) != 1;
            #1;
            checks++;
            if (stall_md !== d_is_md) begin
                errors++;
                $display("FAIL divu_stall cyc%0d: stall=%b want %b", n, stall_md, d_is_md);
            end
            n++;
            @(negedge clk);
        end
        d_is_md = 1'b1;
        #1;
        checks++;
        if (stall_md !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle: stall=%b want 0", stall_md);
        end
        d_is_md = 1'b0;
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL divu_busy_len: got %0d want 10", n);
        end
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL divu_result: hi=%h lo=%h want 2 14", hi, lo);
        end
        hi_m = 32'd2;
        lo_m = 32'd14;
    endtask

    task automatic test_div_neg();
        int n;
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL div_neg: hi=%h lo=%h want ffffffff fffffffd", hi, lo);
        end
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        checks++;
        if (hi !== 32'd0 || lo !== 32'h80000000) begin
            errors++;
            $display("FAIL div_ovf: hi=%h lo=%h want 0 80000000", hi, lo);
        end
        hi_m = 32'd0;
        lo_m = 32'h80000000;
    endtask

    task automatic test_div_zero();
        int n;
        issue(3'd5, 32'h1234, 32'd0);
        checks++;
        if (hi !== 32'h1234 || lo !== 32'h80000000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h lo=%h busy=%b want 1234 80000000 0", hi, lo, busy);
        end
        issue(3'd6, 32'h5678, 32'd0);
        checks++;
        if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b want 1234 5678 0", hi, lo, busy);
        end
        issue(3'd3, 32'hDEAD, 32'd0);
        wait_idle(n);
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL divz_busy_len: got %0d want 10", n);
        end
        checks++;
        if (hi !== 32'h1234 || lo !== 32'h5678) begin
            errors++;
            $display("FAIL divz_result: hi=%h lo=%h want 1234 5678", hi, lo);
        end
        hi_m = 32'h1234;
        lo_m = 32'h5678;
    endtask

    task automatic test_reset_abort();
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL abort: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL late_write: hi=%h lo=%h want 0 0", hi, lo);
        end
        issue(3'd6, 32'hAA, 32'd0);
        checks++;
        if (hi !== 32'd0 || lo !== 32'hAA) begin
            errors++;
            $display("FAIL mtlo_after_abort: hi=%h lo=%h want 0 aa", hi, lo);
        end
        hi_m = 32'd0;
        lo_m = 32'hAA;
    endtask

    task automatic test_start_busy();
        int n;
        issue(3'd3, 32'd1000, 32'd7);
        @(negedge clk);
        @(negedge clk);
        $display("note: MULT issued while busy (expected to be ignored)");
        start = 1'b1;
        md_op = 3'd1;
        rs_data = 32'd9;
        rt_data = 32'd9;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        wait_idle(n);
        checks++;
        if (n + 3 != 10) begin
            errors++;
            $display("FAIL busy_ignore_len: got %0d want 10", n + 3);
        end
        checks++;
        if (hi !== 32'd6 || lo !== 32'd142) begin
            errors++;
            $display("FAIL busy_ignore_result: hi=%h lo=%h want 6 8e", hi, lo);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || lo !== 32'd142) begin
            errors++;
            $display("FAIL busy_no_extend: busy=%b lo=%h want 0 8e", busy, lo);
        end
        hi_m = 32'd6;
        lo_m = 32'd142;
    endtask

    task automatic test_random();
        int n;
        logic [2:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 5) == 0) b = 32'hFFFFFFFF;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            exp = model(op, a, b, hi_m, lo_m);
            issue(op, a, b);
            wait_idle(n);
            checks++;
            if (n != latency(op)) begin
                errors++;
                $display("FAIL rand%0d_len op=%0d: got %0d want %0d", i, op, n, latency(op));
            end
            checks++;
            if (hi !== exp[63:32] || lo !== exp[31:0]) begin
                errors++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: hi=%h lo=%h want %h %h",
                         i, op, a, b, hi, lo, exp[63:32], exp[31:0]);
            end
            hi_m = exp[63:32];
            lo_m = exp[31:0];
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu_stall();
        test_div_neg();
        test_div_zero();
        test_reset_abort();
        test_start_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
